// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS-subset controller
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_MEM, WB_R, WB_I, BRANCH, JUMP, JUMP_REG, HALT
    } state_t;
    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } icls_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_ADDU   = 6'b100001;
    localparam logic [5:0] F_SUBU   = 6'b100011;
    localparam logic [5:0] F_JR     = 6'b001000;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
    function automatic state_t class_next(input icls_t c);
        case (c)
            C_ADDU, C_SUBU: return EXE_R;
            C_JR:           return JUMP_REG;
            C_ORI, C_LUI:   return EXE_I;
            C_LW, C_SW:     return MEM_ADDR;
            C_BEQ:          return BRANCH;
            C_J, C_JAL:     return JUMP;
            default:        return FETCH;
        endcase
    endfunction
endpackage

// File: rtl/mc_instr_decode.sv
// mc_instr_decode: maps op/funct to instruction class and legality
module mc_instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output icls_t      cls,
    output logic       legal
);
    always_comb begin
        cls = C_ILL;
        case (op)
            OP_RTYPE: cls = (funct == F_ADDU || funct == F_SLL) ? C_ADDU :
                            funct == F_SUBU ? C_SUBU :
                            funct == F_JR   ? C_JR   : C_ILL;
            OP_ORI:   cls = C_ORI;
            OP_LUI:   cls = C_LUI;
            OP_LW:    cls = C_LW;
            OP_SW:    cls = C_SW;
            OP_BEQ:   cls = C_BEQ;
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            default:  cls = C_ILL;
        endcase
    end
    assign legal = cls != C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM control; MULTICYCLE_CTRL_ILLEGAL_EN traps unsupported ops in HALT
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       extOp,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       illegal
);
    state_t state, state_n, st;
    icls_t  cls, cls_q;
    logic   legal;
    mc_instr_decode u_dec (.op(op), .funct(funct), .cls(cls), .legal(legal));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cls_q <= C_ADDU;
        end else begin
            state <= state_n;
            if (state == DECODE) cls_q <= cls;
        end
    end
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    logic ill_q;
    always_ff @(posedge clk) begin
        if (reset) ill_q <= 1'b0;
        else if (state == DECODE && !legal) ill_q <= 1'b1;
    end
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif
    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:    state_n = DECODE;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
            DECODE:   state_n = legal ? class_next(cls) : HALT;
`else
            DECODE:   state_n = legal ? class_next(cls) : FETCH;
`endif
            EXE_R:    state_n = WB_R;
            EXE_I:    state_n = WB_I;
            MEM_ADDR: state_n = cls_q == C_LW ? MEM_RD : MEM_WR;
            MEM_RD:   state_n = WB_MEM;
            HALT:     state_n = HALT;
            default:  state_n = FETCH;
        endcase
    end
    // outputs show the FETCH decode while reset is held, whatever the state register holds
    assign st = reset ? FETCH : state;
    always_comb begin
        aluOp    = ALU_ADD;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_REG;
        extOp    = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PC_ALU;
        irWrite  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        regDst   = DST_RT;
        memToReg = M2R_ALU;
        case (st)
            FETCH:    begin irWrite = 1'b1; pcWrite = 1'b1; aluSrcB = SRCB_FOUR; end
            DECODE:   begin aluSrcB = SRCB_IMM_SH; extOp = 1'b1; end
            EXE_R:    begin aluSrcA = 1'b1; aluOp = cls_q == C_SUBU ? ALU_SUB : ALU_ADD; end
            EXE_I:    begin aluSrcA = 1'b1; aluSrcB = SRCB_IMM; aluOp = cls_q == C_LUI ? ALU_LUI : ALU_OR; end
            MEM_ADDR: begin aluSrcA = 1'b1; aluSrcB = SRCB_IMM; extOp = 1'b1; end
            MEM_WR:   memWrite = 1'b1;
            WB_MEM:   begin regWrite = 1'b1; memToReg = M2R_MDR; end
            WB_R:     begin regWrite = 1'b1; regDst = DST_RD; end
            WB_I:     regWrite = 1'b1;
            BRANCH:   begin aluSrcA = 1'b1; aluOp = ALU_SUB; pcSrc = PC_ALUOUT; pcWrite = zero; end
            JUMP:     begin
                pcWrite  = 1'b1;
                pcSrc    = PC_JUMP;
                regWrite = cls_q == C_JAL;
                regDst   = cls_q == C_JAL ? DST_RA : DST_RT;
                memToReg = cls_q == C_JAL ? M2R_PC : M2R_ALU;
            end
            JUMP_REG: begin pcWrite = 1'b1; pcSrc = PC_REGA; end
            default:  ;
        endcase
    end
endmodule
